// File: rtl/div_pkg.sv
// Shared definitions for the signed non-restoring divider: FSM states,
// the default operand width and the step-counter width.
package div_pkg;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        CORRECT,
        SIGN,
        DONE
    } div_state_e;

endpackage

// File: rtl/div_nr_step.sv
// One radix-2 non-restoring add/subtract step on the WIDTH+1-bit partial
// remainder; the quotient bit is the inverted sign of the result.
module div_nr_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH-1:0] y_abs,
    input  logic             sub,
    output logic [WIDTH:0]   a_out,
    output logic             q_bit
);

    logic [WIDTH:0] y_ext;

    always_comb begin
        y_ext = {1'b0, y_abs};
        a_out = sub ? (a_in - y_ext) : (a_in + y_ext);
        q_bit = ~a_out[WIDTH];
    end

endmodule

// File: rtl/divider.sv
// Signed truncating divider, radix-2 non-restoring, WIDTH+3 cycles per result.
// Define DIVIDER_DBZ_EN to short-circuit divide-by-zero and raise dbz.
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int CW = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] yabs_q, yabs_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sx_q, sx_d;
    logic             sq_q, sq_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
`ifdef DIVIDER_DBZ_EN
    logic             dbz_q, dbz_d;
`endif

    logic [WIDTH:0]   step_a_in;
    logic [WIDTH:0]   step_a_out;
    logic             step_sub;
    logic             step_q;
    logic [WIDTH-1:0] rem_mag;

    // The single step unit serves both the ITER shift-and-step and the
    // CORRECT restore (unshifted A, add |Y|).
    always_comb begin
        step_a_in = a_q;
        step_sub  = 1'b0;
        if (state_q == ITER) begin
            step_a_in = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
            step_sub  = ~a_q[WIDTH];
        end
    end

    div_nr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_in  (step_a_in),
        .y_abs (yabs_q),
        .sub   (step_sub),
        .a_out (step_a_out),
        .q_bit (step_q)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        yabs_d  = yabs_q;
        q_d     = q_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        sx_d    = sx_q;
        sq_d    = sq_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        rem_mag = a_q[WIDTH-1:0];
`ifdef DIVIDER_DBZ_EN
        dbz_d   = dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = dividend;
                    y_d     = divisor;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                q_d     = x_q[WIDTH-1] ? -x_q : x_q;
                yabs_d  = y_q[WIDTH-1] ? -y_q : y_q;
                a_d     = '0;
                cnt_d   = '0;
                sx_d    = x_q[WIDTH-1];
                sq_d    = x_q[WIDTH-1] ^ y_q[WIDTH-1];
                state_d = ITER;
`ifdef DIVIDER_DBZ_EN
                if (y_q == '0) begin
                    quo_d   = '0;
                    rem_d   = x_q;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            ITER: begin
                a_d   = step_a_out;
                q_d   = {q_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = CORRECT;
                end
            end
            CORRECT: begin
                if (a_q[WIDTH]) begin
                    a_d = step_a_out;
                end
                state_d = SIGN;
            end
            SIGN: begin
                // Magnitude -2^(WIDTH-1) negates onto itself, which gives the
                // required wrap for the most-negative / -1 case.
                quo_d   = sq_q ? -q_q : q_q;
                rem_d   = sx_q ? -rem_mag : rem_mag;
`ifdef DIVIDER_DBZ_EN
                dbz_d   = 1'b0;
`endif
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            yabs_q  <= '0;
            q_q     <= '0;
            a_q     <= '0;
            cnt_q   <= '0;
            sx_q    <= 1'b0;
            sq_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef DIVIDER_DBZ_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            yabs_q  <= yabs_d;
            q_q     <= q_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            sx_q    <= sx_d;
            sq_q    <= sq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
`ifdef DIVIDER_DBZ_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
`ifdef DIVIDER_DBZ_EN
    assign dbz       = dbz_q;
`else
    assign dbz       = 1'b0;
`endif

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes arithmetic-model results,
// a monitor pops and compares on every done pulse.
module tb_divider;

    localparam int W   = 32;
    localparam int LAT = W + 3;

    typedef struct {
        int         x;
        int         y;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic       dbz;
        int         lat;
        int         acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    divider #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Truncating signed division from plain integer arithmetic.
    function automatic exp_t model(input int x, input int y);
        exp_t e;
        e.x   = x;
        e.y   = y;
        e.dbz = 1'b0;
        e.lat = LAT;
        e.acc = 0;
        if (y == 0) begin
`ifdef DIVIDER_DBZ_EN
            e.q   = '0;
            e.r   = x;
            e.dbz = 1'b1;
            e.lat = 1;
`else
            e.q   = (x >= 0) ? -1 : 1;
            e.r   = x;
`endif
        end else if (x == 32'sh80000000 && y == -1) begin
            e.q = x;
            e.r = '0;
        end else begin
            e.q = x / y;
            e.r = x % y;
        end
        return e;
    endfunction

    task automatic chk1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic launch(input int x, input int y, input bit push);
        exp_t e;
        @(negedge clk);
        start    = 1'b1;
        dividend = x;
        divisor  = y;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        e        = model(x, y);
        e.acc    = cyc;
        if (push) sb.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((busy || sb.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got busy=%b pending=%0d after %0d cycles, required idle and drained",
                     busy, sb.size(), n);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_dbz"}, dbz, 1'b0);
        chk32({tag, "_quotient"}, quotient, 32'd0);
        chk32({tag, "_remainder"}, remainder, 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (rst_b && done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done: got done=1 q=%h r=%h, required no done pulse",
                             quotient, remainder);
                end else begin
                    e   = sb.pop_front();
                    lat = cyc - e.acc;
                    if (quotient !== e.q || remainder !== e.r || dbz !== e.dbz || lat != e.lat) begin
                        errors++;
                        $display("FAIL div %0d/%0d: got q=%h r=%h dbz=%b lat=%0d, required q=%h r=%h dbz=%b lat=%0d",
                                 e.x, e.y, quotient, remainder, dbz, lat, e.q, e.r, e.dbz, e.lat);
                    end else begin
                        $display("txn %0d / %0d -> q=%h r=%h dbz=%b lat=%0d ok",
                                 e.x, e.y, quotient, remainder, dbz, lat);
                    end
                end
            end
        end
    end

    initial begin
        int x;
        int y;
        int n;
        rst_b    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #3 rst_b = 1'b0;
        #1;
        chk_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_b = 1'b1;

        launch(100, 7, 1'b1);              wait_drain(60);
        launch(-100, 7, 1'b1);             wait_drain(60);
        launch(100, -7, 1'b1);             wait_drain(60);
        launch(32'sh80000000, -1, 1'b1);   wait_drain(60);
        launch(7, 100, 1'b1);              wait_drain(60);
        launch(5, 0, 1'b1);                wait_drain(60);
        launch(-5, 0, 1'b1);               wait_drain(60);

        // New operands presented at edge 10 of a busy operation.
        launch(1000, 3, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd999;
        divisor  = 32'd11;
        chk1("busy_mid_op", busy, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_drain(60);
        repeat (5) @(negedge clk);
        chk1("no_relaunch_from_busy", busy, 1'b0);

        // start held in the DONE cycle must not launch anything.
        launch(-77, 5, 1'b1);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk1("done_reached", done, 1'b1);
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk1("start_in_done_ignored", busy, 1'b0);
        wait_drain(60);

        // Reset asserted at edge 20 of an operation.
        launch(12345, 67, 1'b0);
        repeat (20) @(posedge clk);
        #2;
        chk1("busy_before_abort", busy, 1'b1);
        rst_b = 1'b0;
        #1;
        chk_outputs_zero("abort");
        @(negedge clk);
        rst_b = 1'b1;
        repeat (45) @(negedge clk);
        chk1("idle_after_abort", busy, 1'b0);
        launch(-12345, 67, 1'b1);
        wait_drain(60);

        for (int i = 0; i < 30; i++) begin
            x = $urandom;
            if ($urandom_range(0, 1) == 1) x = int'($urandom_range(0, 1000)) - 500;
            case ($urandom_range(0, 3))
                0:       y = $urandom;
                1:       y = int'($urandom_range(1, 64));
                2:       y = -int'($urandom_range(1, 64));
                default: y = (i % 7 == 3) ? 0 : int'($urandom_range(1, 3));
            endcase
            launch(x, y, 1'b1);
            wait_drain(60);
        end

        chk32("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
